// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// Holds the FSM state encodings, the owner encodings and a small ownership helper.
package mux_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_t;

    // Owner encodings double as the mux select value for that requester.
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    function automatic logic owns(input state_t st, input logic side);
        return side ? (st == ST_OWN_B) : (st == ST_OWN_A);
    endfunction

endpackage

// File: rtl/mux_arbiter_mux2x1.sv
// Plain 2:1 datapath mux shared by the two requesters.
// Select 0 picks in0 (requester A), select 1 picks in1 (requester B).
module mux2x1 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    output logic [DATA_WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between requesters A and B, with a
// single registered output stage under valid/ready flow control and a burst cap.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_req_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    output logic                  a_ack_o,
    input  logic                  b_req_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  b_ack_o,
    output logic                  sel_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);

    localparam int              CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state_reg;
    logic             last_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic                  space;
    logic                  transfer;
    logic                  burst_done;
    logic [DATA_WIDTH-1:0] mux_data;

    mux2x1 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mux (
        .sel (sel_o),
        .in0 (a_data_i),
        .in1 (b_data_i),
        .out (mux_data)
    );

    // The output register can take a word if it is empty or being drained this cycle.
    assign space      = !out_valid_o || out_ready_i;
    assign a_ack_o    = owns(state_reg, OWN_A) && a_req_i && space;
    assign b_ack_o    = owns(state_reg, OWN_B) && b_req_i && space;
    assign transfer   = a_ack_o || b_ack_o;
    assign burst_done = transfer && (cnt_reg == CNT_LAST);
    assign cnt_next   = burst_done ? '0 : cnt_reg + CNT_W'(transfer);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            last_reg    <= OWN_B;
            cnt_reg     <= '0;
            sel_o       <= OWN_A;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
        end else begin
            if (transfer) begin
                out_data_o  <= mux_data;
                out_valid_o <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (a_req_i && (!b_req_i || last_reg == OWN_B)) begin
                        state_reg <= ST_OWN_A;
                        last_reg  <= OWN_A;
                        sel_o     <= OWN_A;
                    end else if (b_req_i) begin
                        state_reg <= ST_OWN_B;
                        last_reg  <= OWN_B;
                        sel_o     <= OWN_B;
                    end
                end

                ST_OWN_A: begin
                    // Hand over when the burst cap is hit or A has nothing left.
                    if (b_req_i && (burst_done || !a_req_i)) begin
                        state_reg <= ST_OWN_B;
                        last_reg  <= OWN_B;
                        sel_o     <= OWN_B;
                        cnt_reg   <= '0;
                    end else if (!a_req_i && !b_req_i) begin
                        state_reg <= ST_IDLE;
                        sel_o     <= OWN_A;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                ST_OWN_B: begin
                    if (a_req_i && (burst_done || !b_req_i)) begin
                        state_reg <= ST_OWN_A;
                        last_reg  <= OWN_A;
                        sel_o     <= OWN_A;
                        cnt_reg   <= '0;
                    end else if (!a_req_i && !b_req_i) begin
                        state_reg <= ST_IDLE;
                        sel_o     <= OWN_A;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    sel_o     <= OWN_A;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: reset, single requester, round robin, backpressure,
// early handover, burst wrap and asynchronous reset mid-burst.
module tb_mux_arbiter;

    logic        clk;
    logic        rst;
    logic        a_req;
    logic [15:0] a_data;
    logic        a_ack;
    logic        b_req;
    logic [15:0] b_data;
    logic        b_ack;
    logic        sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int total;
    int fails;

    mux_arbiter #(
        .DATA_WIDTH(16),
        .MAX_BURST (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .a_req_i     (a_req),
        .a_data_i    (a_data),
        .a_ack_o     (a_ack),
        .b_req_i     (b_req),
        .b_data_i    (b_data),
        .b_ack_o     (b_ack),
        .sel_o       (sel),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        a_req     = 1'b0;
        b_req     = 1'b0;
        a_data    = '0;
        b_data    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        a_req     = 1'b1;
        b_req     = 1'b1;
        a_data    = 16'hFFFF;
        b_data    = 16'hEEEE;
        out_ready = 1'b1;
        tick();
        tick();
        #1;
        total++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        total++; if (out_data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h expected 0000", out_data); end
        total++; if (sel !== 1'b0) begin fails++; $display("FAIL reset_sel: got %b expected 0", sel); end
        total++; if (a_ack !== 1'b0) begin fails++; $display("FAIL reset_a_ack: got %b expected 0", a_ack); end
        total++; if (b_ack !== 1'b0) begin fails++; $display("FAIL reset_b_ack: got %b expected 0", b_ack); end
        $display("test_reset: outputs held at reset values");
    endtask

    task automatic test_a_only();
        do_reset();
        out_ready = 1'b1;
        a_req     = 1'b1;
        a_data    = 16'h1111;
        #1;
        total++; if (a_ack !== 1'b0) begin fails++; $display("FAIL a_only_c0_ack: got %b expected 0", a_ack); end
        tick();
        #1;
        total++; if (a_ack !== 1'b1) begin fails++; $display("FAIL a_only_c1_ack: got %b expected 1", a_ack); end
        total++; if (sel !== 1'b0) begin fails++; $display("FAIL a_only_c1_sel: got %b expected 0", sel); end
        tick();
        a_data = 16'h2222;
        #1;
        total++; if (a_ack !== 1'b1) begin fails++; $display("FAIL a_only_c2_ack: got %b expected 1", a_ack); end
        total++; if (out_data !== 16'h1111) begin fails++; $display("FAIL a_only_c2_data: got %h expected 1111", out_data); end
        total++; if (out_valid !== 1'b1) begin fails++; $display("FAIL a_only_c2_valid: got %b expected 1", out_valid); end
        tick();
        a_req = 1'b0;
        #1;
        total++; if (a_ack !== 1'b0) begin fails++; $display("FAIL a_only_c3_ack: got %b expected 0", a_ack); end
        total++; if (out_data !== 16'h2222) begin fails++; $display("FAIL a_only_c3_data: got %h expected 2222", out_data); end
        total++; if (out_valid !== 1'b1) begin fails++; $display("FAIL a_only_c3_valid: got %b expected 1", out_valid); end
        tick();
        #1;
        total++; if (out_valid !== 1'b0) begin fails++; $display("FAIL a_only_c4_valid: got %b expected 0", out_valid); end
        $display("test_a_only: words 1111 and 2222 sent by A");
    endtask

    task automatic test_round_robin();
        logic        exp_a;
        logic        exp_b;
        logic        exp_sel;
        logic [15:0] exp_data;
        do_reset();
        out_ready = 1'b1;
        a_req     = 1'b1;
        b_req     = 1'b1;
        a_data    = 16'hA5A5;
        b_data    = 16'h5B5B;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_a   = ((i >= 1) && (i <= 4)) || (i == 9);
            exp_b   = (i >= 5) && (i <= 8);
            exp_sel = (i >= 5) && (i <= 8);
            total++; if (a_ack !== exp_a) begin fails++; $display("FAIL rr_a_ack c%0d: got %b expected %b", i, a_ack, exp_a); end
            total++; if (b_ack !== exp_b) begin fails++; $display("FAIL rr_b_ack c%0d: got %b expected %b", i, b_ack, exp_b); end
            total++; if (sel !== exp_sel) begin fails++; $display("FAIL rr_sel c%0d: got %b expected %b", i, sel, exp_sel); end
            if (i >= 2) begin
                exp_data = (i - 1 <= 4) ? 16'hA5A5 : 16'h5B5B;
                total++; if (out_data !== exp_data) begin fails++; $display("FAIL rr_data c%0d: got %h expected %h", i, out_data, exp_data); end
            end
            tick();
        end
        a_req = 1'b0;
        b_req = 1'b0;
        $display("test_round_robin: 4 A words, 4 B words, then A again");
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        a_req     = 1'b1;
        a_data    = 16'hABCD;
        #1;
        total++; if (a_ack !== 1'b0) begin fails++; $display("FAIL bp_c0_ack: got %b expected 0", a_ack); end
        tick();
        #1;
        total++; if (a_ack !== 1'b1) begin fails++; $display("FAIL bp_c1_ack: got %b expected 1", a_ack); end
        tick();
        a_data    = 16'h1234;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            total++; if (a_ack !== 1'b0) begin fails++; $display("FAIL bp_stall_ack s%0d: got %b expected 0", j, a_ack); end
            total++; if (out_data !== 16'hABCD) begin fails++; $display("FAIL bp_stall_data s%0d: got %h expected abcd", j, out_data); end
            total++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_stall_valid s%0d: got %b expected 1", j, out_valid); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (a_ack !== 1'b1) begin fails++; $display("FAIL bp_resume_ack: got %b expected 1", a_ack); end
        total++; if (out_data !== 16'hABCD) begin fails++; $display("FAIL bp_resume_data: got %h expected abcd", out_data); end
        tick();
        a_req = 1'b0;
        #1;
        total++; if (out_data !== 16'h1234) begin fails++; $display("FAIL bp_next_data: got %h expected 1234", out_data); end
        total++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_next_valid: got %b expected 1", out_valid); end
        total++; if (a_ack !== 1'b0) begin fails++; $display("FAIL bp_next_ack: got %b expected 0", a_ack); end
        tick();
        #1;
        total++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain_valid: got %b expected 0", out_valid); end
        total++; if (out_data !== 16'h1234) begin fails++; $display("FAIL bp_drain_data: got %h expected 1234", out_data); end
        $display("test_backpressure: abcd held through 3-cycle stall, 1234 followed once");
    endtask

    task automatic test_drop_switch();
        logic exp_a;
        logic exp_b;
        logic exp_sel;
        do_reset();
        out_ready = 1'b1;
        a_req     = 1'b1;
        b_req     = 1'b1;
        a_data    = 16'h1357;
        b_data    = 16'h2468;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) a_req = 1'b0;
            if (i == 4) a_req = 1'b1;
            #1;
            exp_a   = (i == 1) || (i == 2) || (i == 8);
            exp_b   = (i >= 4) && (i <= 7);
            exp_sel = (i >= 4) && (i <= 7);
            total++; if (a_ack !== exp_a) begin fails++; $display("FAIL drop_a_ack c%0d: got %b expected %b", i, a_ack, exp_a); end
            total++; if (b_ack !== exp_b) begin fails++; $display("FAIL drop_b_ack c%0d: got %b expected %b", i, b_ack, exp_b); end
            total++; if (sel !== exp_sel) begin fails++; $display("FAIL drop_sel c%0d: got %b expected %b", i, sel, exp_sel); end
            if (i == 5) begin
                total++; if (out_data !== 16'h2468) begin fails++; $display("FAIL drop_b_data: got %h expected 2468", out_data); end
            end
            tick();
        end
        a_req = 1'b0;
        b_req = 1'b0;
        $display("test_drop_switch: A dropped after 2 words, B got a full burst of 4");
    endtask

    task automatic test_burst_wrap();
        logic exp_a;
        logic exp_b;
        do_reset();
        out_ready = 1'b1;
        a_req     = 1'b1;
        a_data    = 16'h0F0F;
        b_data    = 16'hF0F0;
        for (int i = 0; i < 10; i++) begin
            if (i == 7) b_req = 1'b1;
            #1;
            exp_a = (i >= 1) && (i <= 8);
            exp_b = (i == 9);
            total++; if (a_ack !== exp_a) begin fails++; $display("FAIL wrap_a_ack c%0d: got %b expected %b", i, a_ack, exp_a); end
            total++; if (b_ack !== exp_b) begin fails++; $display("FAIL wrap_b_ack c%0d: got %b expected %b", i, b_ack, exp_b); end
            tick();
        end
        a_req = 1'b0;
        b_req = 1'b0;
        $display("test_burst_wrap: A kept grant past 4 words, yielded at wrapped count end");
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b1;
        b_req     = 1'b1;
        b_data    = 16'hC0DE;
        tick();
        #1;
        total++; if (b_ack !== 1'b1) begin fails++; $display("FAIL mrst_b_ack: got %b expected 1", b_ack); end
        tick();
        #1;
        total++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mrst_pre_valid: got %b expected 1", out_valid); end
        total++; if (sel !== 1'b1) begin fails++; $display("FAIL mrst_pre_sel: got %b expected 1", sel); end
        total++; if (out_data !== 16'hC0DE) begin fails++; $display("FAIL mrst_pre_data: got %h expected c0de", out_data); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_valid: got %b expected 0", out_valid); end
        total++; if (sel !== 1'b0) begin fails++; $display("FAIL mrst_sel: got %b expected 0", sel); end
        total++; if (out_data !== 16'h0000) begin fails++; $display("FAIL mrst_data: got %h expected 0000", out_data); end
        total++; if (b_ack !== 1'b0) begin fails++; $display("FAIL mrst_b_ack_rst: got %b expected 0", b_ack); end
        total++; if (a_ack !== 1'b0) begin fails++; $display("FAIL mrst_a_ack_rst: got %b expected 0", a_ack); end
        tick();
        rst   = 1'b0;
        a_req = 1'b1;
        b_req = 1'b1;
        #1;
        total++; if ((a_ack | b_ack) !== 1'b0) begin fails++; $display("FAIL mrst_idle_ack: got %b expected 0", a_ack | b_ack); end
        tick();
        #1;
        total++; if (a_ack !== 1'b1) begin fails++; $display("FAIL mrst_tie_a_ack: got %b expected 1", a_ack); end
        total++; if (b_ack !== 1'b0) begin fails++; $display("FAIL mrst_tie_b_ack: got %b expected 0", b_ack); end
        total++; if (sel !== 1'b0) begin fails++; $display("FAIL mrst_tie_sel: got %b expected 0", sel); end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        $display("test_mid_reset: B burst cleared by reset, A won following tie");
    endtask

    initial begin
        total     = 0;
        fails     = 0;
        rst       = 1'b1;
        a_req     = 1'b0;
        b_req     = 1'b0;
        a_data    = '0;
        b_data    = '0;
        out_ready = 1'b0;
        test_reset();
        test_a_only();
        test_round_robin();
        test_backpressure();
        test_drop_switch();
        test_burst_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
        $finish;
    end

endmodule
